// File: rtl/dmem_arbiter.sv
// Two-port (cpu / loader) arbiter in front of a single-ported data memory.
// Round-robin by default; define DMEM_ARB_FIXED_PRIO_EN for fixed cpu priority.
module dmem_arbiter #(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DATA_W = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_stall,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              ld_req,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  output logic              ld_gnt,
  output logic              ld_rvalid,
  output logic [DATA_W-1:0] ld_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [15:0]       cpu_gnt_cnt,
  output logic [15:0]       ld_gnt_cnt
);

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_LD  = 1'b1
  } owner_e;

  owner_e            last_gnt;
  owner_e            owner;
  logic              rd_pend;
  logic              cpu_win;
  logic [DATA_W-1:0] cpu_rdata_q;
  logic [DATA_W-1:0] ld_rdata_q;
  logic [15:0]       cpu_cnt;
  logic [15:0]       ld_cnt;

  // Grants are gated by reset so nothing reaches memory while reset is held.
  always_comb begin
    cpu_gnt = 1'b0;
    ld_gnt  = 1'b0;
`ifdef DMEM_ARB_FIXED_PRIO_EN
    cpu_win = 1'b1;
`else
    cpu_win = (last_gnt == OWN_LD);
`endif
    if (reset) begin
      if (cpu_req && (!ld_req || cpu_win)) begin
        cpu_gnt = 1'b1;
      end else if (ld_req) begin
        ld_gnt = 1'b1;
      end
    end
  end

  always_comb begin
    mem_en    = cpu_gnt | ld_gnt;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (cpu_gnt) begin
      mem_we    = cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else if (ld_gnt) begin
      mem_we    = ld_we;
      mem_addr  = ld_addr;
      mem_wdata = ld_wdata;
    end
  end

  assign cpu_stall = reset & cpu_req & ~cpu_gnt;

  // Memory returns read data one cycle after the command; route it by the owner tag.
  assign cpu_rvalid  = rd_pend && (owner == OWN_CPU);
  assign ld_rvalid   = rd_pend && (owner == OWN_LD);
  assign cpu_rdata   = cpu_rvalid ? mem_rdata : cpu_rdata_q;
  assign ld_rdata    = ld_rvalid  ? mem_rdata : ld_rdata_q;
  assign cpu_gnt_cnt = cpu_cnt;
  assign ld_gnt_cnt  = ld_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_gnt    <= OWN_LD;
      owner       <= OWN_CPU;
      rd_pend     <= 1'b0;
      cpu_rdata_q <= '0;
      ld_rdata_q  <= '0;
      cpu_cnt     <= '0;
      ld_cnt      <= '0;
    end else begin
      if (cpu_gnt) begin
        last_gnt <= OWN_CPU;
      end else if (ld_gnt) begin
        last_gnt <= OWN_LD;
      end
      rd_pend <= mem_en & ~mem_we;
      if (mem_en) begin
        owner <= ld_gnt ? OWN_LD : OWN_CPU;
      end
      if (cpu_rvalid) begin
        cpu_rdata_q <= mem_rdata;
      end
      if (ld_rvalid) begin
        ld_rdata_q <= mem_rdata;
      end
      if (cpu_gnt && (cpu_cnt != '1)) begin
        cpu_cnt <= cpu_cnt + 16'd1;
      end
      if (ld_gnt && (ld_cnt != '1)) begin
        ld_cnt <= ld_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: vector table plus reset, contention and saturation sequences.
module tb_dmem_arbiter;

`ifdef DMEM_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [63:0] cpu_addr = '0, cpu_wdata = '0;
  logic        cpu_gnt, cpu_stall, cpu_rvalid;
  logic [63:0] cpu_rdata;
  logic        ld_req = 1'b0, ld_we = 1'b0;
  logic [63:0] ld_addr = '0, ld_wdata = '0;
  logic        ld_gnt, ld_rvalid;
  logic [63:0] ld_rdata;
  logic        mem_en, mem_we;
  logic [63:0] mem_addr, mem_wdata;
  logic [63:0] mem_rdata = '0;
  logic [15:0] cpu_gnt_cnt, ld_gnt_cnt;

  int unsigned n_chk = 0;
  int unsigned n_fail = 0;

  dmem_arbiter #(.ADDR_W(64), .DATA_W(64)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
    .ld_gnt(ld_gnt), .ld_rvalid(ld_rvalid), .ld_rdata(ld_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .cpu_gnt_cnt(cpu_gnt_cnt), .ld_gnt_cnt(ld_gnt_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        c_req, c_we;
    logic [63:0] c_addr, c_wdata;
    logic        l_req, l_we;
    logic [63:0] l_addr, l_wdata, m_rdata;
    logic        e_cg, e_lg, e_st, e_men, e_mwe;
    logic [63:0] e_maddr, e_mwdata;
    logic        e_crv;
    logic [63:0] e_crd;
    logic        e_lrv;
    logic [63:0] e_lrd;
    logic [15:0] e_ccnt, e_lcnt;
  } vec_t;

  function automatic vec_t mk(
    logic cr, logic cw, logic [63:0] ca, logic [63:0] cd,
    logic lr, logic lw, logic [63:0] la, logic [63:0] ldd, logic [63:0] mr,
    logic cg, logic lg, logic st, logic men, logic mwe, logic [63:0] ma, logic [63:0] md,
    logic crv, logic [63:0] crd, logic lrv, logic [63:0] lrd, logic [15:0] cc, logic [15:0] lc);
    vec_t v;
    v.c_req = cr; v.c_we = cw; v.c_addr = ca; v.c_wdata = cd;
    v.l_req = lr; v.l_we = lw; v.l_addr = la; v.l_wdata = ldd; v.m_rdata = mr;
    v.e_cg = cg; v.e_lg = lg; v.e_st = st; v.e_men = men; v.e_mwe = mwe;
    v.e_maddr = ma; v.e_mwdata = md;
    v.e_crv = crv; v.e_crd = crd; v.e_lrv = lrv; v.e_lrd = lrd;
    v.e_ccnt = cc; v.e_lcnt = lc;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    cpu_req = 1'b0; cpu_we = 1'b0; ld_req = 1'b0; ld_we = 1'b0;
  endtask

  vec_t vecs[8];

  initial begin
    logic        exp_last, cwin, prev_valid, prev_cpu;
    logic [15:0] m_ccnt, m_lcnt;

    vecs[0] = mk(0,0,64'h0,64'h0,     0,0,64'h0,64'h0,         64'h0,
                 0,0,0,0,0,64'h0,64'h0,                0,64'h0,    0,64'h0,    16'd0,16'd0);
    vecs[1] = mk(1,0,64'h100,64'h11,  1,0,64'h200,64'h22,      64'h0,
                 1,0,0,1,0,64'h100,64'h11,             0,64'h0,    0,64'h0,    16'd0,16'd0);
    vecs[2] = mk(0,0,64'h0,64'h0,     1,0,64'h200,64'h22,      64'hAAAA,
                 0,1,0,1,0,64'h200,64'h22,             1,64'hAAAA, 0,64'h0,    16'd1,16'd0);
    vecs[3] = mk(0,0,64'h0,64'h0,     0,0,64'h0,64'h0,         64'hBBBB,
                 0,0,0,0,0,64'h0,64'h0,                0,64'hAAAA, 1,64'hBBBB, 16'd1,16'd1);
    vecs[4] = mk(0,0,64'h0,64'h0,     1,1,64'h10,64'hDEADBEEF, 64'hCCCC,
                 0,1,0,1,1,64'h10,64'hDEADBEEF,        0,64'hAAAA, 0,64'hBBBB, 16'd1,16'd1);
    vecs[5] = mk(0,0,64'h0,64'h0,     0,0,64'h0,64'h0,         64'hDDDD,
                 0,0,0,0,0,64'h0,64'h0,                0,64'hAAAA, 0,64'hBBBB, 16'd1,16'd2);
    vecs[6] = mk(1,1,64'h40,64'h77,   0,0,64'h0,64'h0,         64'hEEEE,
                 1,0,0,1,1,64'h40,64'h77,              0,64'hAAAA, 0,64'hBBBB, 16'd1,16'd2);
    vecs[7] = mk(0,0,64'h0,64'h0,     0,0,64'h0,64'h0,         64'hFFFF,
                 0,0,0,0,0,64'h0,64'h0,                0,64'hAAAA, 0,64'hBBBB, 16'd2,16'd2);

    // Reset state with both ports requesting.
    cpu_req = 1'b1; ld_req = 1'b1; cpu_we = 1'b1; ld_we = 1'b1;
    @(negedge clk);
    chk("rst_cpu_gnt", cpu_gnt, 0); chk("rst_ld_gnt", ld_gnt, 0);
    chk("rst_mem_en", mem_en, 0);   chk("rst_mem_we", mem_we, 0);
    chk("rst_stall", cpu_stall, 0); chk("rst_cpu_rvalid", cpu_rvalid, 0);
    chk("rst_ld_rvalid", ld_rvalid, 0);
    chk("rst_cpu_rdata", cpu_rdata, 0); chk("rst_ld_rdata", ld_rdata, 0);
    chk("rst_cpu_cnt", cpu_gnt_cnt, 0); chk("rst_ld_cnt", ld_gnt_cnt, 0);
    idle_inputs();
    reset = 1'b1;

    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      cpu_req = vecs[i].c_req; cpu_we = vecs[i].c_we;
      cpu_addr = vecs[i].c_addr; cpu_wdata = vecs[i].c_wdata;
      ld_req = vecs[i].l_req; ld_we = vecs[i].l_we;
      ld_addr = vecs[i].l_addr; ld_wdata = vecs[i].l_wdata;
      mem_rdata = vecs[i].m_rdata;
      #2;
      chk($sformatf("v%0d_cpu_gnt", i), cpu_gnt, vecs[i].e_cg);
      chk($sformatf("v%0d_ld_gnt", i), ld_gnt, vecs[i].e_lg);
      chk($sformatf("v%0d_stall", i), cpu_stall, vecs[i].e_st);
      chk($sformatf("v%0d_mem_en", i), mem_en, vecs[i].e_men);
      chk($sformatf("v%0d_mem_we", i), mem_we, vecs[i].e_mwe);
      if (vecs[i].e_men) begin
        chk($sformatf("v%0d_mem_addr", i), mem_addr, vecs[i].e_maddr);
        chk($sformatf("v%0d_mem_wdata", i), mem_wdata, vecs[i].e_mwdata);
      end
      chk($sformatf("v%0d_cpu_rvalid", i), cpu_rvalid, vecs[i].e_crv);
      chk($sformatf("v%0d_cpu_rdata", i), cpu_rdata, vecs[i].e_crd);
      chk($sformatf("v%0d_ld_rvalid", i), ld_rvalid, vecs[i].e_lrv);
      chk($sformatf("v%0d_ld_rdata", i), ld_rdata, vecs[i].e_lrd);
      chk($sformatf("v%0d_cpu_cnt", i), cpu_gnt_cnt, vecs[i].e_ccnt);
      chk($sformatf("v%0d_ld_cnt", i), ld_gnt_cnt, vecs[i].e_lcnt);
    end

    // Continuous contention from a fresh reset: 8 back-to-back reads.
    @(negedge clk);
    idle_inputs();
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    exp_last = 1'b1; prev_valid = 1'b0; prev_cpu = 1'b0;
    m_ccnt = '0; m_lcnt = '0;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clk);
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 64'h300;
      ld_req = 1'b1; ld_we = 1'b0; ld_addr = 64'h400;
      mem_rdata = 64'h5000 + 64'(i);
      #2;
      cwin = FIXED || exp_last;
      chk($sformatf("A%0d_cpu_gnt", i), cpu_gnt, cwin);
      chk($sformatf("A%0d_ld_gnt", i), ld_gnt, !cwin);
      chk($sformatf("A%0d_stall", i), cpu_stall, !cwin);
      chk($sformatf("A%0d_mem_addr", i), mem_addr, cwin ? 64'h300 : 64'h400);
      chk($sformatf("A%0d_cpu_rvalid", i), cpu_rvalid, prev_valid && prev_cpu);
      chk($sformatf("A%0d_ld_rvalid", i), ld_rvalid, prev_valid && !prev_cpu);
      if (prev_valid && prev_cpu) chk($sformatf("A%0d_cpu_rdata", i), cpu_rdata, 64'h5000 + 64'(i));
      if (prev_valid && !prev_cpu) chk($sformatf("A%0d_ld_rdata", i), ld_rdata, 64'h5000 + 64'(i));
      prev_valid = 1'b1; prev_cpu = cwin;
      exp_last = !cwin;
      if (cwin) m_ccnt++; else m_lcnt++;
    end
    @(negedge clk);
    idle_inputs();
    mem_rdata = 64'h5008;
    #2;
    chk("A_end_cpu_rvalid", cpu_rvalid, prev_cpu);
    chk("A_end_ld_rvalid", ld_rvalid, !prev_cpu);
    chk("A_end_rdata", prev_cpu ? cpu_rdata : ld_rdata, 64'h5008);
    chk("A_cpu_cnt", cpu_gnt_cnt, FIXED ? 16'd8 : 16'd4);
    chk("A_ld_cnt", ld_gnt_cnt, FIXED ? 16'd0 : 16'd4);
    chk("A_cnt_model", {cpu_gnt_cnt, ld_gnt_cnt}, {m_ccnt, m_lcnt});

    // Reset asserted in the cycle after a cpu read grant drops the return.
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 64'h500;
    #2;
    chk("B_cpu_gnt", cpu_gnt, 1);
    @(negedge clk);
    reset = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b1; ld_req = 1'b1; ld_we = 1'b1;
    mem_rdata = 64'h9999;
    #1;
    chk("B_rst_cpu_rvalid", cpu_rvalid, 0);
    chk("B_rst_cpu_rdata", cpu_rdata, 0);
    chk("B_rst_cpu_gnt", cpu_gnt, 0);
    chk("B_rst_ld_gnt", ld_gnt, 0);
    chk("B_rst_mem_en", mem_en, 0);
    chk("B_rst_mem_we", mem_we, 0);
    chk("B_rst_stall", cpu_stall, 0);
    chk("B_rst_cnt", {cpu_gnt_cnt, ld_gnt_cnt}, 0);
    @(negedge clk);
    chk("B_rst2_cpu_gnt", cpu_gnt, 0);
    chk("B_rst2_mem_en", mem_en, 0);
    idle_inputs();
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk($sformatf("B_post%0d_cpu_rvalid", i), cpu_rvalid, 0);
      chk($sformatf("B_post%0d_cpu_rdata", i), cpu_rdata, 0);
    end

    // Saturation of the cpu grant counter.
    @(negedge clk);
    force dut.cpu_cnt = 16'hFFFE;
    #1;
    release dut.cpu_cnt;
    #1;
    chk("C_preload", cpu_gnt_cnt, 16'hFFFE);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 64'h600;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #2;
      chk($sformatf("C_cnt%0d", i), cpu_gnt_cnt, 16'hFFFF);
    end
    idle_inputs();
    @(negedge clk);
    @(negedge clk);
    chk("C_hold", cpu_gnt_cnt, 16'hFFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 64, meaning byte-address width for both ports and memory.
REQ-002 SHALL have parameter DATA_W, default 64, meaning data width for both ports and memory.
REQ-003 SHALL have port clk, input, 1 bit, meaning the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit, meaning asynchronous, active-low reset.
REQ-005 SHALL have ports cpu_req (input, 1), cpu_we (input, 1), cpu_addr (input, ADDR_W) and cpu_wdata (input, DATA_W), meaning the processor load/store request.
REQ-006 SHALL have ports cpu_gnt (output, 1), cpu_stall (output, 1), cpu_rvalid (output, 1) and cpu_rdata (output, DATA_W), meaning processor grant, stall, read-return valid and read data.
REQ-007 SHALL have ports ld_req, ld_we, ld_addr, ld_wdata, ld_gnt, ld_rvalid and ld_rdata, with the same directions and widths as the cpu_* ports, meaning the test loader/debug port.
REQ-008 SHALL have ports mem_en (output, 1), mem_we (output, 1), mem_addr (output, ADDR_W) and mem_wdata (output, DATA_W), meaning the data-memory command.
REQ-009 SHALL have port mem_rdata, input, DATA_W, meaning data-memory read data, valid one cycle after a read command.
REQ-010 SHALL have ports cpu_gnt_cnt and ld_gnt_cnt, each output, 16 bits, meaning saturating per-port grant counts.

Function
REQ-011 SHALL grant at most one port per cycle; gnt is combinational from req and the arbitration state, and a requester holds req/we/addr/wdata stable until gnt.
REQ-012 SHALL drive mem_en=1 and mem_we/mem_addr/mem_wdata from the granted port in the grant cycle; with no grant, mem_en=0 and mem_we=0.
REQ-013 SHALL, in round-robin mode, grant the sole requester; when both request, SHALL grant the port not granted most recently (register last_gnt, 0=cpu, 1=ld, updated on every grant).
REQ-014 SHALL set cpu_stall = cpu_req AND NOT cpu_gnt.
REQ-015 SHALL, for a granted read (we=0), assert that port's rvalid for exactly one cycle in the following cycle, with rdata = mem_rdata; routing uses a registered owner tag.
REQ-016 SHALL keep rvalid=0 for writes; rdata SHALL hold its last returned value when rvalid=0.
REQ-017 SHALL support back-to-back grants every cycle, including read-after-read on alternating ports, each return routed to its own port.
REQ-018 SHALL increment a port's grant counter on each grant to that port and saturate it at 16'hFFFF with no wrap.

Reset
REQ-019 SHALL, while reset=0, asynchronously force last_gnt=1 (cpu wins the first contention), the owner tag and pending-read flag to 0, cpu_rvalid=ld_rvalid=0, cpu_rdata=ld_rdata=0, and both counters=0.
REQ-020 SHALL, while reset=0, hold cpu_gnt=ld_gnt=0, mem_en=0, mem_we=0 and cpu_stall=0.
REQ-021 SHALL drop a read return pending at reset assertion; no rvalid is produced after reset release for a read issued before reset.

Configuration
REQ-022 SHALL, when macro DMEM_ARB_FIXED_PRIO_EN is defined, use fixed priority (cpu always wins contention; last_gnt is still tracked but ignored); when it is undefined, use the round-robin mode of REQ-013.

Verification
REQ-023 Reset release, then cpu_req=1, ld_req=1, both reads -> cycle 1 cpu_gnt=1, cycle 2 ld_gnt=1; cpu_rvalid in cycle 2, ld_rvalid in cycle 3, each carrying its own mem_rdata.
REQ-024 ld writes 0xDEADBEEF to addr 0x10 alone -> mem_en=1, mem_we=1, mem_addr=0x10, mem_wdata=0xDEADBEEF; ld_rvalid stays 0.
REQ-025 Both ports request continuously for 8 cycles (round-robin) -> grants alternate cpu, ld, cpu, ...; cpu_stall=1 on ld cycles; counters end at 4/4.
REQ-026 Same as REQ-025 with DMEM_ARB_FIXED_PRIO_EN defined -> cpu granted all 8 cycles, ld_gnt_cnt=0.
REQ-027 Assert reset in the cycle after a cpu read grant -> cpu_rvalid never asserts, counters read 0, and no grant occurs while reset=0.
REQ-028 Force cpu_gnt_cnt to 0xFFFE and grant cpu 3 times -> count reads 0xFFFF and holds.
